emif_amm_req_adapter: RTL and testbench

Request/response adapter directly upstream of the DDR4 EMIF controller's Avalon-MM port `ctrl_amm_0`. It accepts single-beat read/write requests from the memory-controller fabric over valid/ready and converts them into Avalon-MM commands that honour waitrequest. Read completions are returned in order with their request tag. Read credits bound the outstanding reads, so read data always has buffer space even when the consumer stalls.

---
 rtl/emif_amm_pkg.sv | 22 ++
 rtl/emif_sync_fifo.sv | 56 +++++
 rtl/emif_amm_req_adapter.sv | 135 +++++++++++++
 tb/tb_emif_amm_req_adapter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emif_amm_pkg.sv
// Shared widths and command record for the EMIF Avalon-MM request adapter.
package emif_amm_pkg;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 576;
    localparam int unsigned BE_W   = 72;
    localparam int unsigned TAG_W  = 8;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic [TAG_W-1:0]  tag;
    } amm_cmd_t;

    // Counter width able to hold the value n itself (0..n).
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/emif_sync_fifo.sv
// Synchronous FIFO with registered storage; head is read straight from the array.
module emif_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = emif_amm_pkg::cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/emif_amm_req_adapter.sv
// Valid/ready request front end for the EMIF ctrl_amm_0 port, with read
// credits so returned read data always has buffer space.
module emif_amm_req_adapter #(
    parameter int unsigned ADDR_W = emif_amm_pkg::ADDR_W,
    parameter int unsigned DATA_W = emif_amm_pkg::DATA_W,
    parameter int unsigned BE_W   = emif_amm_pkg::BE_W,
    parameter int unsigned TAG_W  = emif_amm_pkg::TAG_W,
    parameter int unsigned MAX_RD = 16
) (
    input  logic                    emif_usr_clk,
    input  logic                    emif_usr_reset_n,
    input  logic                    local_cal_success,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    input  logic [BE_W-1:0]         req_be,
    input  logic [TAG_W-1:0]        req_tag,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [TAG_W-1:0]        rsp_tag,
    input  logic                    amm_ready_0,
    output logic                    amm_read_0,
    output logic                    amm_write_0,
    output logic [ADDR_W-1:0]       amm_address_0,
    output logic [DATA_W-1:0]       amm_writedata_0,
    output logic [BE_W-1:0]         amm_byteenable_0,
    output logic [6:0]              amm_burstcount_0,
    input  logic [DATA_W-1:0]       amm_readdata_0,
    input  logic                    amm_readdatavalid_0,
    output logic [$clog2(MAX_RD):0] rd_outstanding,
    output logic                    err_unexp_rd
);

    localparam int unsigned      CNT_W   = emif_amm_pkg::cnt_w(MAX_RD);
    localparam logic [CNT_W-1:0] CREDITS = CNT_W'(MAX_RD);

    logic              hold_valid;
    logic              hold_write;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;
    logic [BE_W-1:0]   hold_be;
    logic [TAG_W-1:0]  hold_tag;

    logic cmd_accept;
    logic rd_accept;
    logic rsp_fire;
    logic tag_empty;
    logic tag_full;
    logic data_empty;
    logic data_full;
    logic unused_full;

    assign amm_write_0      = hold_valid & hold_write;
    assign amm_read_0       = hold_valid & ~hold_write & (rd_outstanding < CREDITS);
    assign amm_address_0    = hold_addr;
    assign amm_writedata_0  = hold_wdata;
    assign amm_byteenable_0 = hold_be;
    assign amm_burstcount_0 = 7'd1;

    assign cmd_accept = (amm_read_0 | amm_write_0) & amm_ready_0;
    assign rd_accept  = amm_read_0 & amm_ready_0;
    assign req_ready  = local_cal_success & (~hold_valid | cmd_accept);
    assign rsp_valid  = ~data_empty;
    assign rsp_fire   = rsp_valid & rsp_ready;

    // Credits bound the data FIFO occupancy, so the full flags never gate anything.
    assign unused_full = tag_full | data_full;

    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            hold_valid <= 1'b0;
            hold_write <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_be    <= '0;
            hold_tag   <= '0;
        end else if (req_valid && req_ready) begin
            hold_valid <= 1'b1;
            hold_write <= req_write;
            hold_addr  <= req_addr;
            hold_wdata <= req_wdata;
            hold_be    <= req_be;
            hold_tag   <= req_tag;
        end else if (cmd_accept) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            rd_outstanding <= '0;
        end else begin
            case ({rd_accept, rsp_fire})
                2'b10:   rd_outstanding <= rd_outstanding + 1'b1;
                2'b01:   rd_outstanding <= rd_outstanding - 1'b1;
                default: rd_outstanding <= rd_outstanding;
            endcase
        end
    end

    // A tag pushed in the same cycle counts as present.
    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            err_unexp_rd <= 1'b0;
        end else if (amm_readdatavalid_0 && tag_empty && !rd_accept) begin
            err_unexp_rd <= 1'b1;
        end
    end

    emif_sync_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_RD)) u_tag_fifo (
        .clk   (emif_usr_clk),
        .rst_n (emif_usr_reset_n),
        .push  (rd_accept),
        .din   (hold_tag),
        .pop   (rsp_fire),
        .dout  (rsp_tag),
        .full  (tag_full),
        .empty (tag_empty)
    );

    emif_sync_fifo #(.WIDTH(DATA_W), .DEPTH(MAX_RD)) u_data_fifo (
        .clk   (emif_usr_clk),
        .rst_n (emif_usr_reset_n),
        .push  (amm_readdatavalid_0),
        .din   (amm_readdata_0),
        .pop   (rsp_fire),
        .dout  (rsp_data),
        .full  (data_full),
        .empty (data_empty)
    );

endmodule

// File: tb/tb_emif_amm_req_adapter.sv
// Directed bench for emif_amm_req_adapter: inputs change on the falling edge,
// outputs are checked 1 ns later.
module tb_emif_amm_req_adapter;
    import emif_amm_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cal;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic              amm_ready;
    logic              amm_read;
    logic              amm_write;
    logic [ADDR_W-1:0] amm_address;
    logic [DATA_W-1:0] amm_writedata;
    logic [BE_W-1:0]   amm_byteenable;
    logic [6:0]        amm_burstcount;
    logic [DATA_W-1:0] amm_readdata;
    logic              amm_rdv;
    logic [4:0]        rd_outstanding;
    logic              err;

    int errors = 0;
    int checks = 0;
    int wr_acc = 0;
    int rd_acc = 0;
    int peak   = 0;

    emif_amm_req_adapter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BE_W   (BE_W),
        .TAG_W  (TAG_W),
        .MAX_RD (16)
    ) dut (
        .emif_usr_clk        (clk),
        .emif_usr_reset_n    (rst_n),
        .local_cal_success   (cal),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_write           (req_write),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .req_be              (req_be),
        .req_tag             (req_tag),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_data            (rsp_data),
        .rsp_tag             (rsp_tag),
        .amm_ready_0         (amm_ready),
        .amm_read_0          (amm_read),
        .amm_write_0         (amm_write),
        .amm_address_0       (amm_address),
        .amm_writedata_0     (amm_writedata),
        .amm_byteenable_0    (amm_byteenable),
        .amm_burstcount_0    (amm_burstcount),
        .amm_readdata_0      (amm_readdata),
        .amm_readdatavalid_0 (amm_rdv),
        .rd_outstanding      (rd_outstanding),
        .err_unexp_rd        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (amm_ready && amm_write) wr_acc++;
        if (amm_ready && amm_read)  rd_acc++;
    end

    always @(negedge clk) begin
        if (int'(rd_outstanding) > peak) peak = int'(rd_outstanding);
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [DATA_W-1:0] mk_data(input logic [31:0] s);
        return {18{s}};
    endfunction

    task automatic drive_req(input logic wr, input logic [ADDR_W-1:0] a,
                             input logic [31:0] seed, input logic [TAG_W-1:0] t);
        amm_cmd_t c;
        c.write = wr;
        c.addr  = a;
        c.wdata = mk_data(seed);
        c.be    = '1;
        c.tag   = t;
        req_write = c.write;
        req_addr  = c.addr;
        req_wdata = c.wdata;
        req_be    = c.be;
        req_tag   = c.tag;
        req_valid = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cal   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (amm_read !== 1'b0) begin errors++; $display("FAIL rst_amm_read got=%b exp=0", amm_read); end
        checks++; if (amm_write !== 1'b0) begin errors++; $display("FAIL rst_amm_write got=%b exp=0", amm_write); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rd_outstanding !== 5'd0) begin errors++; $display("FAIL rst_outstanding got=%0d exp=0", rd_outstanding); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
        checks++; if (amm_address !== '0) begin errors++; $display("FAIL rst_address got=%0h exp=0", amm_address); end
        checks++; if (amm_burstcount !== 7'd1) begin errors++; $display("FAIL rst_burstcount got=%0d exp=1", amm_burstcount); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cal_gating;
        int w0;
        @(negedge clk);
        w0 = wr_acc;
        amm_ready = 1'b1;
        drive_req(1'b1, 28'h55, 32'h5555_0001, 8'h00);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL cal_req_ready%0d got=%b exp=0", i, req_ready); end
            checks++; if ({amm_read, amm_write} !== 2'b00) begin errors++; $display("FAIL cal_strobes%0d got=%b exp=00", i, {amm_read, amm_write}); end
            @(negedge clk);
        end
        cal = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL cal_up_req_ready got=%b exp=1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (amm_write !== 1'b1) begin errors++; $display("FAIL cal_issue_write got=%b exp=1", amm_write); end
        checks++; if (amm_address !== 28'h55) begin errors++; $display("FAIL cal_issue_addr got=%0h exp=55", amm_address); end
        @(negedge clk);
        #1;
        checks++; if (amm_write !== 1'b0) begin errors++; $display("FAIL cal_write_done got=%b exp=0", amm_write); end
        checks++; if (wr_acc - w0 !== 1) begin errors++; $display("FAIL cal_wr_accepts got=%0d exp=1", wr_acc - w0); end
    endtask

    task automatic test_write_wait;
        int w0;
        logic [DATA_W-1:0] d;
        d = mk_data(32'hCAFE_0123);
        @(negedge clk);
        w0 = wr_acc;
        amm_ready = 1'b0;
        drive_req(1'b1, 28'h123, 32'hCAFE_0123, 8'h00);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ww_req_ready got=%b exp=1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (amm_write !== 1'b1) begin errors++; $display("FAIL ww_write%0d got=%b exp=1", i, amm_write); end
            checks++; if (amm_address !== 28'h123) begin errors++; $display("FAIL ww_addr%0d got=%0h exp=123", i, amm_address); end
            checks++; if (amm_writedata !== d) begin errors++; $display("FAIL ww_data%0d got=%0h exp=%0h", i, amm_writedata[31:0], d[31:0]); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ww_req_ready%0d got=%b exp=0", i, req_ready); end
            if (i == 4) amm_ready = 1'b1;
            @(negedge clk);
        end
        #1;
        checks++; if (amm_write !== 1'b0) begin errors++; $display("FAIL ww_write_done got=%b exp=0", amm_write); end
        checks++; if (wr_acc - w0 !== 1) begin errors++; $display("FAIL ww_accepts got=%0d exp=1", wr_acc - w0); end
        checks++; if (rd_outstanding !== 5'd0) begin errors++; $display("FAIL ww_outstanding got=%0d exp=0", rd_outstanding); end
    endtask

    task automatic test_read_order;
        int r0;
        int k;
        int nd;
        @(negedge clk);
        r0 = rd_acc;
        peak = 0;
        rsp_ready = 1'b1;
        amm_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b0, 28'(32'h200 + i), 32'h0, 8'(8'hA0 + i));
            #1;
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ro_req_ready%0d got=%b exp=1", i, req_ready); end
            @(negedge clk);
        end
        req_valid = 1'b0;
        k = 0;
        nd = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            amm_rdv = (cyc == 3) || (cyc == 7) || (cyc == 8) || (cyc == 20);
            amm_readdata = mk_data(32'(32'hD0 + nd));
            if (amm_rdv) nd++;
            #1;
            if (rsp_valid) begin
                checks++; if (rsp_tag !== 8'(8'hA0 + k)) begin errors++; $display("FAIL ro_tag%0d got=%0h exp=%0h", k, rsp_tag, 8'hA0 + k); end
                checks++; if (rsp_data !== mk_data(32'(32'hD0 + k))) begin errors++; $display("FAIL ro_data%0d got=%0h exp=%0h", k, rsp_data[31:0], 32'hD0 + k); end
                k++;
            end
            @(negedge clk);
        end
        amm_rdv = 1'b0;
        #1;
        checks++; if (k !== 4) begin errors++; $display("FAIL ro_rsp_count got=%0d exp=4", k); end
        checks++; if (peak !== 4) begin errors++; $display("FAIL ro_peak got=%0d exp=4", peak); end
        checks++; if (rd_acc - r0 !== 4) begin errors++; $display("FAIL ro_rd_accepts got=%0d exp=4", rd_acc - r0); end
        checks++; if (rd_outstanding !== 5'd0) begin errors++; $display("FAIL ro_outstanding got=%0d exp=0", rd_outstanding); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ro_err got=%b exp=0", err); end
    endtask

    task automatic test_credit_limit;
        int r0;
        int n;
        int pops;
        logic [TAG_W-1:0] last_tag;
        @(negedge clk);
        r0 = rd_acc;
        rsp_ready = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 17; cyc++) begin
            drive_req(1'b0, 28'(32'h300 + n), 32'h0, 8'(8'h10 + n));
            #1;
            if (req_ready) n++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (n !== 17) begin errors++; $display("FAIL cl_handshakes got=%0d exp=17", n); end
        repeat (4) @(negedge clk);
        #1;
        checks++; if (rd_outstanding !== 5'd16) begin errors++; $display("FAIL cl_outstanding_full got=%0d exp=16", rd_outstanding); end
        checks++; if (rd_acc - r0 !== 16) begin errors++; $display("FAIL cl_rd_accepts got=%0d exp=16", rd_acc - r0); end
        checks++; if (amm_read !== 1'b0) begin errors++; $display("FAIL cl_read_blocked got=%b exp=0", amm_read); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL cl_req_ready got=%b exp=0", req_ready); end
        for (int i = 0; i < 16; i++) begin
            amm_rdv = 1'b1;
            amm_readdata = mk_data(32'(32'hE0 + i));
            @(negedge clk);
        end
        amm_rdv = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL cl_rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_tag !== 8'h10) begin errors++; $display("FAIL cl_head_tag got=%0h exp=10", rsp_tag); end
        checks++; if (amm_read !== 1'b0) begin errors++; $display("FAIL cl_read_still_blocked got=%b exp=0", amm_read); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++; if (amm_read !== 1'b1) begin errors++; $display("FAIL cl_read_after_pop got=%b exp=1", amm_read); end
        checks++; if (rd_outstanding !== 5'd15) begin errors++; $display("FAIL cl_outstanding_pop got=%0d exp=15", rd_outstanding); end
        checks++; if (rsp_tag !== 8'h11) begin errors++; $display("FAIL cl_next_tag got=%0h exp=11", rsp_tag); end
        @(negedge clk);
        #1;
        checks++; if (rd_outstanding !== 5'd16) begin errors++; $display("FAIL cl_outstanding_refill got=%0d exp=16", rd_outstanding); end
        checks++; if (rd_acc - r0 !== 17) begin errors++; $display("FAIL cl_rd_accepts_17 got=%0d exp=17", rd_acc - r0); end
        pops = 0;
        last_tag = '0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            amm_rdv = (cyc == 0);
            amm_readdata = mk_data(32'hEF0);
            rsp_ready = 1'b1;
            #1;
            if (rsp_valid) begin
                pops++;
                last_tag = rsp_tag;
            end else if (rd_outstanding == 5'd0) begin
                break;
            end
            @(negedge clk);
        end
        amm_rdv = 1'b0;
        rsp_ready = 1'b0;
        checks++; if (pops !== 16) begin errors++; $display("FAIL cl_drain_pops got=%0d exp=16", pops); end
        checks++; if (last_tag !== 8'h20) begin errors++; $display("FAIL cl_last_tag got=%0h exp=20", last_tag); end
        checks++; if (rd_outstanding !== 5'd0) begin errors++; $display("FAIL cl_drained got=%0d exp=0", rd_outstanding); end
    endtask

    task automatic test_simultaneous;
        @(negedge clk);
        amm_ready = 1'b1;
        rsp_ready = 1'b0;
        drive_req(1'b0, 28'h400, 32'h0, 8'h31);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (rd_outstanding !== 5'd1) begin errors++; $display("FAIL sim_outstanding_a got=%0d exp=1", rd_outstanding); end
        amm_rdv = 1'b1;
        amm_readdata = mk_data(32'h31);
        @(negedge clk);
        amm_rdv = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL sim_rsp_valid_a got=%b exp=1", rsp_valid); end
        drive_req(1'b0, 28'h401, 32'h0, 8'h32);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        checks++; if (amm_read !== 1'b1) begin errors++; $display("FAIL sim_read_b got=%b exp=1", amm_read); end
        checks++; if (rsp_tag !== 8'h31) begin errors++; $display("FAIL sim_tag_a got=%0h exp=31", rsp_tag); end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++; if (rd_outstanding !== 5'd1) begin errors++; $display("FAIL sim_count_unchanged got=%0d exp=1", rd_outstanding); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sim_rsp_popped got=%b exp=0", rsp_valid); end
        amm_rdv = 1'b1;
        amm_readdata = mk_data(32'h32);
        @(negedge clk);
        amm_rdv = 1'b0;
        rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_tag !== 8'h32) begin errors++; $display("FAIL sim_tag_b got=%0h exp=32", rsp_tag); end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++; if (rd_outstanding !== 5'd0) begin errors++; $display("FAIL sim_outstanding_end got=%0d exp=0", rd_outstanding); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sim_err_before got=%b exp=0", err); end
        amm_rdv = 1'b1;
        amm_readdata = mk_data(32'hBAD);
        @(negedge clk);
        amm_rdv = 1'b0;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL sim_err_set got=%b exp=1", err); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL sim_err_sticky got=%b exp=1", err); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        amm_ready = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b0, 28'(32'h500 + i), 32'h0, 8'(8'h40 + i));
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rd_outstanding !== 5'd3) begin errors++; $display("FAIL rm_pending got=%0d exp=3", rd_outstanding); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rd_outstanding !== 5'd0) begin errors++; $display("FAIL rm_async_outstanding got=%0d exp=0", rd_outstanding); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_async_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rm_async_err got=%b exp=0", err); end
        checks++; if ({amm_read, amm_write} !== 2'b00) begin errors++; $display("FAIL rm_async_strobes got=%b exp=00", {amm_read, amm_write}); end
        checks++; if (amm_address !== '0) begin errors++; $display("FAIL rm_async_address got=%0h exp=0", amm_address); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_post_rsp_valid got=%b exp=0", rsp_valid); end
        drive_req(1'b0, 28'h600, 32'h0, 8'h77);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        amm_rdv = 1'b1;
        amm_readdata = mk_data(32'h77);
        @(negedge clk);
        amm_rdv = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rm_new_rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_tag !== 8'h77) begin errors++; $display("FAIL rm_new_tag got=%0h exp=77", rsp_tag); end
        checks++; if (rsp_data !== mk_data(32'h77)) begin errors++; $display("FAIL rm_new_data got=%0h exp=77", rsp_data[31:0]); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rm_new_err got=%b exp=0", err); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++; if (rd_outstanding !== 5'd0) begin errors++; $display("FAIL rm_final_outstanding got=%0d exp=0", rd_outstanding); end
    endtask

    initial begin
        rst_n        = 1'b0;
        cal          = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_be       = '0;
        req_tag      = '0;
        rsp_ready    = 1'b0;
        amm_ready    = 1'b0;
        amm_readdata = '0;
        amm_rdv      = 1'b0;
        test_reset();
        test_cal_gating();
        test_write_wait();
        test_read_order();
        test_credit_limit();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
